// File: rtl/out_channel_reader.sv
// Out channel consumer: circular word buffer drained over valid/ready.
// Define OUT_CHANNEL_CHECK_EN to add the expected-table checker.
module out_channel_reader #(
   parameter int MemoryElementWidth = 12,
   parameter int NOut = 2000,
   parameter int NExpected = 1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic wr_en,
   input  logic [MemoryElementWidth-1:0] wr_data,
   output logic rd_valid,
   input  logic rd_ready,
   output logic [MemoryElementWidth-1:0] rd_data,
   output logic [$clog2(NOut+1)-1:0] count,
`ifdef OUT_CHANNEL_CHECK_EN
   output logic overflow,
   input  logic exp_we,
   input  logic [((NExpected > 1) ? $clog2(NExpected) : 1)-1:0] exp_addr,
   input  logic [MemoryElementWidth-1:0] exp_data,
   input  logic prog_done,
   output logic finished,
   output logic success
`else
   output logic overflow
`endif
);

   localparam int W  = MemoryElementWidth;
   localparam int PW = $clog2(NOut);
   localparam int CW = $clog2(NOut+1);

   logic [W-1:0]  mem [NOut];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          pop;
   logic          push;

   assign rd_valid = (count != '0);
   assign rd_data  = mem[rd_ptr];
   assign full     = (count == CW'(NOut));
   assign pop      = rd_valid && rd_ready;
   // A pop frees the slot in the same cycle, so full does not block push+pop.
   assign push     = wr_en && (!full || pop);

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == PW'(NOut-1)) ? '0 : wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= (rd_ptr == PW'(NOut-1)) ? '0 : rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
         if (wr_en && !push)
            overflow <= 1'b1;
      end
   end

`ifdef OUT_CHANNEL_CHECK_EN
   localparam int EAW = (NExpected > 1) ? $clog2(NExpected) : 1;
   localparam int PCW = $clog2(NExpected+2);

   logic [W-1:0]   expm [2**EAW];
   logic [PCW-1:0] popped;
   logic           mismatch;
   logic           in_range;

   assign in_range = (popped < PCW'(NExpected));

   always_ff @(posedge clock) begin
      if (exp_we) expm[exp_addr] <= exp_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         popped   <= '0;
         mismatch <= 1'b0;
         finished <= 1'b0;
         success  <= 1'b0;
      end else if (!finished) begin
         if (pop) begin
            if (!in_range || rd_data != expm[popped[EAW-1:0]])
               mismatch <= 1'b1;
            if (popped != PCW'(NExpected+1))
               popped <= popped + PCW'(1);
         end
         // count==0 excludes a pop this cycle, so mismatch is already final.
         if (prog_done && !rd_valid && !wr_en) begin
            finished <= 1'b1;
            success  <= !mismatch && !overflow &&
                        (popped == PCW'(NExpected));
         end
      end
   end
`endif

endmodule

// File: tb/tb_out_channel_reader.sv
// Directed bench for out_channel_reader: NOut=4 and NOut=3 instances
// share stimulus; checker sequence runs when OUT_CHANNEL_CHECK_EN is set.
module tb_out_channel_reader;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        wr_en;
   logic        rd_ready;
   logic [11:0] wr_data;

   logic        rd_valid4, overflow4;
   logic [11:0] rd_data4;
   logic [2:0]  count4;
   logic        rd_valid3, overflow3;
   logic [11:0] rd_data3;
   logic [1:0]  count3;

`ifdef OUT_CHANNEL_CHECK_EN
   logic        exp_we, exp_addr, prog_done;
   logic [11:0] exp_data;
   logic        finished4, success4, finished3, success3;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clock = ~clock;

   out_channel_reader #(.MemoryElementWidth(12), .NOut(4), .NExpected(1)) u4 (
      .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
      .rd_valid(rd_valid4), .rd_ready(rd_ready), .rd_data(rd_data4),
      .count(count4),
`ifdef OUT_CHANNEL_CHECK_EN
      .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
      .prog_done(prog_done), .finished(finished4), .success(success4),
`endif
      .overflow(overflow4)
   );

   out_channel_reader #(.MemoryElementWidth(12), .NOut(3), .NExpected(1)) u3 (
      .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
      .rd_valid(rd_valid3), .rd_ready(rd_ready), .rd_data(rd_data3),
      .count(count3),
`ifdef OUT_CHANNEL_CHECK_EN
      .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
      .prog_done(prog_done), .finished(finished3), .success(success3),
`endif
      .overflow(overflow3)
   );

   typedef struct packed {
      logic        rst;
      logic        we;
      logic [11:0] wd;
      logic        rr;
      logic [3:0]  ecnt;
      logic        evld;
      logic        dchk;
      logic [11:0] edat;
      logic        eovf;
   } vec_t;

   vec_t v [25];

   function automatic vec_t mk(input logic rst, input logic we,
                               input int wd, input logic rr,
                               input int ecnt, input logic evld,
                               input logic dchk, input int edat,
                               input logic eovf);
      vec_t r;
      r.rst  = rst;
      r.we   = we;
      r.wd   = 12'(wd);
      r.rr   = rr;
      r.ecnt = 4'(ecnt);
      r.evld = evld;
      r.dchk = dchk;
      r.edat = 12'(edat);
      r.eovf = eovf;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic we, input int wd, input logic rr);
      wr_en    = we;
      wr_data  = 12'(wd);
      rd_ready = rr;
   endtask

   task automatic pulse_rst();
      drive(1'b0, 0, 1'b0);
`ifdef OUT_CHANNEL_CHECK_EN
      prog_done = 1'b0;
      exp_we    = 1'b0;
`endif
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      v[0]  = mk(0,0,0,0, 0,0,0,0,0);
      v[1]  = mk(0,1,2,1, 0,0,0,0,0);
      v[2]  = mk(0,0,0,1, 1,1,1,2,0);
      v[3]  = mk(0,0,0,0, 0,0,0,0,0);
      v[4]  = mk(0,1,1,0, 0,0,0,0,0);
      v[5]  = mk(0,1,2,0, 1,1,1,1,0);
      v[6]  = mk(0,1,3,0, 2,1,1,1,0);
      v[7]  = mk(0,1,4,0, 3,1,1,1,0);
      v[8]  = mk(0,1,5,0, 4,1,1,1,0);
      v[9]  = mk(0,0,0,0, 4,1,1,1,1);
      v[10] = mk(0,0,0,1, 4,1,1,1,1);
      v[11] = mk(0,0,0,1, 3,1,1,2,1);
      v[12] = mk(0,0,0,1, 2,1,1,3,1);
      v[13] = mk(0,0,0,1, 1,1,1,4,1);
      v[14] = mk(0,0,0,0, 0,0,0,0,1);
      v[15] = mk(1,1,1,0, 0,0,0,0,0);
      v[16] = mk(0,1,2,0, 1,1,1,1,0);
      v[17] = mk(0,1,3,0, 2,1,1,1,0);
      v[18] = mk(0,1,4,0, 3,1,1,1,0);
      v[19] = mk(0,1,9,1, 4,1,1,1,0);
      v[20] = mk(0,0,0,1, 4,1,1,2,0);
      v[21] = mk(0,0,0,1, 3,1,1,3,0);
      v[22] = mk(0,0,0,1, 2,1,1,4,0);
      v[23] = mk(0,0,0,1, 1,1,1,9,0);
      v[24] = mk(0,0,0,0, 0,0,0,0,0);

      reset_n = 1'b0;
      drive(1'b0, 0, 1'b0);
`ifdef OUT_CHANNEL_CHECK_EN
      exp_we    = 1'b0;
      exp_addr  = 1'b0;
      exp_data  = '0;
      prog_done = 1'b0;
`endif
      #12 reset_n = 1'b1;
      step();

      for (int i = 0; i < 25; i++) begin
         if (v[i].rst) pulse_rst();
         chk($sformatf("v%0d count", i), 32'(count4), 32'(v[i].ecnt));
         chk($sformatf("v%0d rd_valid", i), 32'(rd_valid4), 32'(v[i].evld));
         chk($sformatf("v%0d overflow", i), 32'(overflow4), 32'(v[i].eovf));
         if (v[i].dchk)
            chk($sformatf("v%0d rd_data", i), 32'(rd_data4), 32'(v[i].edat));
         drive(v[i].we, 32'(v[i].wd), v[i].rr);
         step();
      end

      // NOut=3 streaming: pointers wrap twice, occupancy stays at most 1.
      pulse_rst();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("wrap%0d count", i), 32'(count3), (i == 0) ? 0 : 1);
         if (i > 0)
            chk($sformatf("wrap%0d rd_data", i), 32'(rd_data3), i - 1);
         drive(i < 7, i, 1'b1);
         step();
      end
      chk("wrap end count", 32'(count3), 0);

      // Asynchronous reset while buffers hold data.
      pulse_rst();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 20 + i, 1'b0);
         step();
      end
      drive(1'b0, 0, 1'b0);
      chk("pre-rst overflow3", 32'(overflow3), 1);
      chk("pre-rst count4", 32'(count4), 4);
      reset_n = 1'b0;
      #1;
      chk("async count4", 32'(count4), 0);
      chk("async rd_valid4", 32'(rd_valid4), 0);
      chk("async overflow3", 32'(overflow3), 0);
      chk("async count3", 32'(count3), 0);
      #1 reset_n = 1'b1;
      step();

`ifdef OUT_CHANNEL_CHECK_EN
      pulse_rst();
      exp_we   = 1'b1;
      exp_addr = 1'b0;
      exp_data = 12'd2;
      drive(1'b1, 2, 1'b0);
      step();
      exp_we = 1'b0;
      chk("chkA finished early", 32'(finished4), 0);
      drive(1'b0, 0, 1'b1);
      step();
      drive(1'b0, 0, 1'b0);
      prog_done = 1'b1;
      step();
      chk("chkA finished", 32'(finished4), 1);
      chk("chkA success", 32'(success4), 1);

      pulse_rst();
      chk("chkB finished rst", 32'(finished4), 0);
      drive(1'b1, 3, 1'b0);
      step();
      drive(1'b0, 0, 1'b1);
      step();
      drive(1'b0, 0, 1'b0);
      prog_done = 1'b1;
      step();
      chk("chkB finished", 32'(finished4), 1);
      chk("chkB success", 32'(success4), 0);

      drive(1'b1, 5, 1'b0);
      step();
      drive(1'b1, 6, 1'b0);
      step();
      drive(1'b0, 0, 1'b1);
      step();
      drive(1'b0, 0, 1'b0);
      chk("chkC count", 32'(count4), 1);
      reset_n = 1'b0;
      #1;
      chk("chkC rd_valid", 32'(rd_valid4), 0);
      chk("chkC count0", 32'(count4), 0);
      chk("chkC overflow", 32'(overflow4), 0);
      chk("chkC finished", 32'(finished4), 0);
      chk("chkC success", 32'(success4), 0);
      #1 reset_n = 1'b1;
      prog_done = 1'b0;
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
